// File: rtl/fetch_pkg.sv
// Shared state encoding, NOP constant and skid-entry type for the instruction-fetch stage.
package fetch_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;
   localparam logic [1:0] ST_FULL = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      DROP = ST_DROP,
      FULL = ST_FULL
   } fetch_state_e;

   localparam logic [31:0] RESET_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } fetch_word_t;

   localparam fetch_word_t FETCH_WORD_NOP = '{instr: RESET_INSTR, pc: 32'h0};

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register; loads in 1 cycle, unload/clear empty it.
// Clear wins over load, load wins over unload; no backpressure of its own.
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic        unload_i,
   input  logic        clear_i,
   input  fetch_word_t word_i,
   output fetch_word_t word_o,
   output logic        valid_o
);

   fetch_word_t word_q, word_d;
   logic        valid_q, valid_d;

   always_comb begin
      word_d  = word_q;
      valid_d = valid_q;
      if (clear_i) begin
         word_d  = FETCH_WORD_NOP;
         valid_d = 1'b0;
      end else if (load_i) begin
         word_d  = word_i;
         valid_d = 1'b1;
      end else if (unload_i) begin
         word_d  = FETCH_WORD_NOP;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q  <= FETCH_WORD_NOP;
         valid_q <= 1'b0;
      end else begin
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign word_o  = word_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: presents pc to imem, captures the word into IF/ID one cycle after imem_ready, skid on decode stall.
// Backpressure: pc_advance stays low while memory or a full skid stalls; FETCH_PERF_EN adds fetch/stall counters.
module fetch_unit
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pc_advance,
   input  logic        flush,
   input  logic        id_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count
`endif
);

   fetch_state_e state_q, state_d;
   logic         imem_req_q, imem_req_d;
   logic [31:0]  drop_addr_q, drop_addr_d;
   logic [31:0]  instr_q, instr_d;
   logic [31:0]  instr_pc_q, instr_pc_d;
   logic         instr_valid_q, instr_valid_d;

   logic         acc;
   logic         adv;
   logic         skid_load, skid_unload, skid_clear, skid_vld;
   fetch_word_t  skid_in, skid_out;

   assign acc     = !instr_valid_q || !id_stall;
   assign skid_in = '{instr: imem_rdata, pc: pc};

   always_comb begin
      state_d       = state_q;
      drop_addr_d   = drop_addr_q;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      adv           = 1'b0;
      skid_load     = 1'b0;
      skid_unload   = 1'b0;
      skid_clear    = 1'b0;

      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (flush) begin
               // An unfinished request cannot be withdrawn; park its address until memory answers.
               if (!imem_ready) begin
                  drop_addr_d = pc;
                  state_d     = DROP;
               end
            end else if (imem_ready) begin
               adv = 1'b1;
               if (acc) begin
                  instr_d       = imem_rdata;
                  instr_pc_d    = pc;
                  instr_valid_d = 1'b1;
               end else begin
                  skid_load = 1'b1;
                  state_d   = FULL;
               end
            end else if (acc) begin
               instr_valid_d = 1'b0;
            end
         end
         DROP: begin
            if (imem_ready) state_d = REQ;
         end
         FULL: begin
            if (flush) begin
               state_d = REQ;
            end else if (!id_stall) begin
               instr_d       = skid_out.instr;
               instr_pc_d    = skid_out.pc;
               instr_valid_d = 1'b1;
               skid_unload   = 1'b1;
               state_d       = REQ;
            end
         end
      endcase

      if (flush) begin
         adv           = 1'b1;
         instr_valid_d = 1'b0;
         instr_d       = RESET_INSTR;
         skid_clear    = 1'b1;
      end
   end

   assign imem_req_d = (state_d == REQ) || (state_d == DROP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         imem_req_q    <= 1'b0;
         drop_addr_q   <= 32'h0;
         instr_q       <= RESET_INSTR;
         instr_pc_q    <= 32'h0;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         imem_req_q    <= imem_req_d;
         drop_addr_q   <= drop_addr_d;
         instr_q       <= instr_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   fetch_skid_buf u_skid (
      .clk      (clk),
      .rst      (rst),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (skid_clear),
      .word_i   (skid_in),
      .word_o   (skid_out),
      .valid_o  (skid_vld)
   );

   assign pc_advance  = adv;
   assign imem_req    = imem_req_q;
   assign imem_addr   = (state_q == DROP) ? drop_addr_q : pc;
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         if (instr_valid_q && !id_stall && !flush) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (imem_req_q && !imem_ready)            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

   addr_stable_a: assert property (@(posedge clk) disable iff (rst)
      (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr)));

   skid_full_a: assert property (@(posedge clk) disable iff (rst)
      ((state_q == FULL) == skid_vld));

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly downstream of the program counter register and upstream of decode. It presents the current PC to instruction memory over a req/ready handshake, captures the returned word into the IF/ID output register, and tells the PC register when to advance. A one-entry skid buffer absorbs a fetch that completes while decode is stalled. A flush discards in-flight and buffered instructions.

## Interface
- RESET_INSTR, 32'h0000_0000, value driven on `instr` and `skid` word at reset and on flush (NOP)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- pc  in  32  current PC from the PC register
- pc_advance  out  1  PC register must load its next value at this edge; 0 means hold
- flush  in  1  redirect/kill from execute; the PC takes the redirect target this edge
- id_stall  in  1  decode cannot accept `instr` this cycle
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address; stable while `imem_req`=1 and `imem_ready`=0
- imem_ready  in  1  `imem_rdata` valid and request completed this cycle
- imem_rdata  in  32  fetched word
- instr  out  32  IF/ID instruction
- instr_pc  out  32  address `instr` was fetched from
- instr_valid  out  1  `instr` is live

## Operation
- Reset: state IDLE, `imem_req`=0, `instr`=RESET_INSTR, `instr_pc`=0, `instr_valid`=0, skid empty, `pc_advance`=0.
- Accept condition: `acc` = !instr_valid || !id_stall.
- IDLE: no request; unconditionally → REQ next cycle.
- REQ: `imem_req`=1, `imem_addr`=pc.
  - flush (any ready): `pc_advance`=1, `instr_valid`←0. If `imem_ready`: data dropped, stay REQ. If not: drop_addr←pc, → DROP.
  - ready & acc: instr←rdata, instr_pc←pc, instr_valid←1, `pc_advance`=1, stay REQ.
  - ready & !acc: skid←{rdata, pc}, `pc_advance`=1, → FULL.
  - no ready & !flush: `pc_advance`=0; if acc, instr_valid←0.
- DROP: `imem_req`=1, `imem_addr`=drop_addr; on ready: data discarded, → REQ, `pc_advance`=0. Flush in DROP: `pc_advance`=1, stay DROP.
- FULL: `imem_req`=0, `pc_advance`=0. !id_stall: output←skid, skid cleared, → REQ. Flush: `instr_valid`←0, skid cleared, `pc_advance`=1, → REQ.
- Flush has priority over id_stall and over capture.
- Flush also clears the skid and sets `instr`=RESET_INSTR.
- `pc_advance` is combinational from state, `imem_ready`, `flush`, `id_stall`.
- `instr_pc` is a 32-bit copy of `pc`; no arithmetic performed in this block.

## Timing
- Zero-wait memory (ready same cycle as req): one instruction per cycle; `instr_valid` rises the cycle after the completing edge.
- First request issues on the second cycle after reset release.
- Latency: ready in cycle N → `instr` visible in N+1.
- Decode stall of k cycles with memory ready: at most one extra fetch (into skid); no request issued while FULL.
- Reset asserted mid-request: all state cleared immediately; the outstanding request is abandoned (memory is reset by the same `rst`).

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `fetch_count` (32, counts cycles with instr_valid & !id_stall & !flush) and `stall_count` (32, counts cycles with imem_req & !imem_ready). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; the rest of the behaviour is identical.

## Structure
- Shared package `fetch_pkg`: state encoding (IDLE, REQ, DROP, FULL as 2-bit localparams) and the NOP constant.
- One sub-module `fetch_skid_buf`: a one-entry {instr, pc} register with load, unload, clear and valid signals.

## Test plan
- Reset, then ready held at 1 with pc stepping by 4 from 0 → instr_pc 0, 4, 8 on consecutive cycles; instr_valid=1 from cycle 3.
- Ready delayed 3 cycles at pc=0x40 → imem_addr stays 0x40, pc_advance=0 for 3 cycles, then 1; instr_pc=0x40.
- id_stall high for 4 cycles with ready=1 → one skid load; FULL; imem_req=0; after release the skid word appears, then fetching resumes with no loss or duplication.
- Flush while in REQ with ready=0 at pc=0x100, redirect to 0x200 → DROP; imem_addr held at 0x100 until ready; next request is to 0x200; 0x100 data never valid.
- Flush in FULL → instr_valid=0, skid cleared, next fetch issued from the redirect PC.
- With `FETCH_PERF_EN`: 10 delivered instructions and 3 wait cycles → fetch_count=10, stall_count=3.
